bist_tpg_ctrl: RTL and testbench
================================

BIST_TPG_CTRL -- requirements
Module: bist_tpg_ctrl

Interface
REQ-001 Parameter NPAT, default 7: number of test patterns per run, legal range 1..15.
REQ-002 Parameter SEED, default 9'h001: LFSR seed loaded at run start.
REQ-003 Parameter GOLDEN, default 4'h0: expected 4-bit signature, set per CUT.
REQ-004 Parameter TIMEOUT, default 8'd32: maximum cycles spent waiting for signature completion.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: level request to run a BIST session.
REQ-008 Port enc, input, 1: signature compactor completion flag.
REQ-009 Port sig, input, 4: signature value from the compactor.
REQ-010 Port pattern, output, 9: test vector to the CUT; {cin, b[3:0], a[3:0]} = pattern[8:0].
REQ-011 Port ens, output, 1: enable to the signature compactor.
REQ-012 Port busy, output, 1: high in RUN and WAIT.
REQ-013 Port done, output, 1: high in DONE.
REQ-014 Port pass, output, 1: result; valid while done=1.
REQ-015 Port timeout, output, 1: high in DONE when the session ended by timeout.
REQ-016 Port pat_cnt, output, 4: number of patterns applied in the current run.

Function
REQ-017 The LFSR shall implement x^9+x^5+1, Fibonacci form: next = {lfsr[7:0], lfsr[8]^lfsr[4]}.
REQ-018 If SEED==0, the block shall load 9'h001 instead (lock-up avoidance).
REQ-019 The FSM shall have states IDLE, RUN, WAIT, DONE, all registered.
REQ-020 IDLE: outputs at reset values; start=1 -> load lfsr=seed, pat_cnt=0, go to RUN.
REQ-021 RUN: ens=1 and pattern=lfsr; each cycle the LFSR advances and pat_cnt increments; after NPAT cycles -> WAIT.
REQ-022 enc seen in RUN shall be ignored.
REQ-023 WAIT: ens stays 1 (the compactor clears when ens drops); pattern holds the last applied value; a timeout counter increments each cycle.
REQ-024 WAIT with enc=1 -> DONE; the block shall capture pass=(sig==GOLDEN) and set timeout=0 on that edge.
REQ-025 WAIT with no enc for TIMEOUT cycles -> DONE with pass=0 and timeout=1.
REQ-026 When enc=1 on the final timeout cycle, enc shall take priority (normal completion).
REQ-027 DONE: ens=0, done=1; pass, timeout, pat_cnt and pattern hold.
REQ-028 DONE exits to IDLE only when start=0; start held high shall not retrigger a run.
REQ-029 On DONE->IDLE, pass, timeout and pat_cnt shall clear.
REQ-030 start deasserting during RUN or WAIT shall not abort the session.
REQ-031 Latency from start=1 sampled in IDLE to the first pattern with ens=1 shall be 1 cycle.

Reset
REQ-032 rst=0 shall immediately force: state IDLE, lfsr=0, pattern=0, ens=0, busy=0, done=0, pass=0, timeout=0, pat_cnt=0, timeout counter=0.
REQ-033 Reset asserted mid-RUN or mid-WAIT shall abort the session with no result retained.
REQ-034 After rst deasserts, a new run shall require start=1 sampled in IDLE.

Verification
REQ-035 Defaults, start pulse: pattern = 001,002,004,008,010,021,042 on consecutive cycles with ens=1, then WAIT holding 042, pat_cnt=7.
REQ-036 In WAIT, drive enc=1 with sig=GOLDEN -> next cycle done=1, pass=1, timeout=0, ens=0.
REQ-037 In WAIT, drive enc=1 with sig!=GOLDEN -> done=1, pass=0.
REQ-038 enc never asserted -> DONE after 32 WAIT cycles with timeout=1, pass=0; enc on cycle 32 -> timeout=0.
REQ-039 rst=0 on the 4th RUN cycle -> all outputs 0 asynchronously; no run until a new start.
REQ-040 start held high through DONE -> stays DONE; start=0 -> IDLE with pass=0; start=1 again -> pattern sequence restarts at 001.

Source files
------------

// File: rtl/bist_tpg_ctrl.sv
// BIST test-pattern-generator controller: drives an x^9+x^5+1 LFSR pattern burst
// into the CUT, then waits for the signature compactor and grades its signature.
module bist_tpg_ctrl #(
    parameter int unsigned NPAT    = 7,
    parameter logic [8:0]  SEED    = 9'h001,
    parameter logic [3:0]  GOLDEN  = 4'h0,
    parameter logic [7:0]  TIMEOUT = 8'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enc,
    input  logic [3:0] sig,
    output logic [8:0] pattern,
    output logic       ens,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [3:0] pat_cnt
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [8:0] SEED_EFF = (SEED == 9'd0) ? 9'h001 : SEED;
    localparam logic [3:0] NPAT_L   = 4'(NPAT);
    localparam logic [7:0] TLAST    = (TIMEOUT == 8'd0) ? 8'd0 : TIMEOUT - 8'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state;
    logic [8:0] lfsr;
    logic [7:0] tcnt;

    assign pattern = lfsr;

    // The LFSR register is the applied pattern; it freezes on the last vector
    // so WAIT and DONE keep presenting what the CUT last saw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            lfsr    <= 9'd0;
            tcnt    <= 8'd0;
            ens     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
            pat_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        lfsr    <= SEED_EFF;
                        pat_cnt <= 4'd0;
                        tcnt    <= 8'd0;
                        ens     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    pat_cnt <= pat_cnt + 4'd1;
                    if (pat_cnt + 4'd1 == NPAT_L) begin
                        state <= S_WAIT;
                        tcnt  <= 8'd0;
                    end else begin
                        lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
                    end
                end
                S_WAIT: begin
                    // A completion flag on the last allowed cycle still counts as normal completion.
                    if (enc) begin
                        state   <= S_DONE;
                        pass    <= (sig == GOLDEN);
                        timeout <= 1'b0;
                        ens     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (tcnt >= TLAST) begin
                        state   <= S_DONE;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                        ens     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state   <= S_IDLE;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        pat_cnt <= 4'd0;
                        lfsr    <= 9'd0;
                        tcnt    <= 8'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// Directed bench for bist_tpg_ctrl: a vector table for the main pass flow plus
// hand-written sequences for failing signature, timeout boundary and mid-run reset.
module tb_bist_tpg_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       enc;
    logic [3:0] sig;
    logic [8:0] pattern;
    logic       ens;
    logic       busy;
    logic       done;
    logic       pass;
    logic       tout;
    logic [3:0] pat_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       enc;
        logic [3:0] sig;
        logic [8:0] pat;
        logic       ens;
        logic       busy;
        logic       done;
        logic       pass;
        logic       tout;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[15];

    bist_tpg_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .enc     (enc),
        .sig     (sig),
        .pattern (pattern),
        .ens     (ens),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .timeout (tout),
        .pat_cnt (pat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk_vec(input logic s, input logic e, input logic [3:0] g,
                                    input logic [8:0] p, input logic en, input logic b,
                                    input logic d, input logic ps, input logic t,
                                    input logic [3:0] c);
        vec_t v;
        v.start = s; v.enc = e; v.sig = g;
        v.pat = p; v.ens = en; v.busy = b; v.done = d; v.pass = ps; v.tout = t; v.cnt = c;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled on the following falling edge.
    task automatic applyStimulus(input logic s, input logic e, input logic [3:0] g);
        start = s;
        enc   = e;
        sig   = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [8:0] p, input logic en,
                               input logic b, input logic d, input logic ps,
                               input logic t, input logic [3:0] c);
        logic [17:0] act;
        logic [17:0] exp;
        act = {pattern, ens, busy, done, pass, tout, pat_cnt};
        exp = {p, en, b, d, ps, t, c};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got pat=%h ens=%b busy=%b done=%b pass=%b to=%b cnt=%0d, required pat=%h ens=%b busy=%b done=%b pass=%b to=%b cnt=%0d",
                     name, pattern, ens, busy, done, pass, tout, pat_cnt, p, en, b, d, ps, t, c);
        end
    endtask

    task automatic run_to_wait();
        applyStimulus(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        enc   = 1'b0;
        sig   = 4'h0;

        // Main pass flow, including enc ignored in RUN and start held through DONE.
        vecs[0]  = mk_vec(1, 0, 4'h0, 9'h001, 1, 1, 0, 0, 0, 4'd0);
        vecs[1]  = mk_vec(0, 1, 4'h0, 9'h002, 1, 1, 0, 0, 0, 4'd1);
        vecs[2]  = mk_vec(0, 0, 4'h0, 9'h004, 1, 1, 0, 0, 0, 4'd2);
        vecs[3]  = mk_vec(0, 0, 4'h0, 9'h008, 1, 1, 0, 0, 0, 4'd3);
        vecs[4]  = mk_vec(0, 0, 4'h0, 9'h010, 1, 1, 0, 0, 0, 4'd4);
        vecs[5]  = mk_vec(0, 0, 4'h0, 9'h021, 1, 1, 0, 0, 0, 4'd5);
        vecs[6]  = mk_vec(0, 1, 4'h0, 9'h042, 1, 1, 0, 0, 0, 4'd6);
        vecs[7]  = mk_vec(0, 1, 4'h0, 9'h042, 1, 1, 0, 0, 0, 4'd7);
        vecs[8]  = mk_vec(0, 0, 4'h0, 9'h042, 1, 1, 0, 0, 0, 4'd7);
        vecs[9]  = mk_vec(0, 1, 4'h0, 9'h042, 0, 0, 1, 1, 0, 4'd7);
        vecs[10] = mk_vec(1, 0, 4'h0, 9'h042, 0, 0, 1, 1, 0, 4'd7);
        vecs[11] = mk_vec(1, 1, 4'h5, 9'h042, 0, 0, 1, 1, 0, 4'd7);
        vecs[12] = mk_vec(0, 0, 4'h0, 9'h000, 0, 0, 0, 0, 0, 4'd0);
        vecs[13] = mk_vec(1, 0, 4'h0, 9'h001, 1, 1, 0, 0, 0, 4'd0);
        vecs[14] = mk_vec(0, 0, 4'h0, 9'h002, 1, 1, 0, 0, 0, 4'd1);

        repeat (2) @(negedge clk);
        checkOutput("reset_state", 9'h000, 0, 0, 0, 0, 0, 4'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("idle_no_start", 9'h000, 0, 0, 0, 0, 0, 4'd0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].start, vecs[i].enc, vecs[i].sig);
            checkOutput($sformatf("vec%0d", i), vecs[i].pat, vecs[i].ens, vecs[i].busy,
                        vecs[i].done, vecs[i].pass, vecs[i].tout, vecs[i].cnt);
        end

        // Continue the restarted run into WAIT and complete it with a wrong signature.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("restart_wait", 9'h042, 1, 1, 0, 0, 0, 4'd7);
        applyStimulus(1'b0, 1'b1, 4'hA);
        checkOutput("bad_sig_done", 9'h042, 0, 0, 1, 0, 0, 4'd7);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("bad_sig_idle", 9'h000, 0, 0, 0, 0, 0, 4'd0);

        // Timeout: 31 WAIT cycles stay busy, the 32nd ends the session.
        run_to_wait();
        for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("wait_cycle31", 9'h042, 1, 1, 0, 0, 0, 4'd7);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("timeout_done", 9'h042, 0, 0, 1, 0, 1, 4'd7);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("timeout_idle", 9'h000, 0, 0, 0, 0, 0, 4'd0);

        // enc on the final allowed cycle wins over the timeout.
        run_to_wait();
        for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h0);
        checkOutput("enc_on_last", 9'h042, 0, 0, 1, 1, 0, 4'd7);
        applyStimulus(1'b0, 1'b0, 4'h0);

        // Reset during the 4th RUN cycle aborts asynchronously.
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("run_cycle4", 9'h008, 1, 1, 0, 0, 0, 4'd3);
        #2 rst = 1'b0;
        #1 checkOutput("async_reset", 9'h000, 0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("post_reset_idle", 9'h000, 0, 0, 0, 0, 0, 4'd0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("post_reset_start", 9'h001, 1, 1, 0, 0, 0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
